rob_rd_sched: RTL and testbench

Read-response scheduler and reorder-buffer controller for the AXI interconnect read path. It owns the 4-entry outstanding-read ID buffer: it allocates an entry on every accepted AR and retires the entry on the RLAST beat. It arbitrates the three slave R channels onto the single master R channel, granting only responses that are oldest for their master. Once a burst is granted, the grant is locked until RLAST. The R data/ID mux sits outside and is steered by `r_grant`.

---
 rtl/rob_rd_sched.sv | 247 ++++++++++++++++++++++++
 tb/tb_rob_rd_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_rd_sched.sv
// rob_rd_sched: read-response scheduler and reorder-buffer controller.
//
// Keeps a compacted list of outstanding read IDs, with ent[0] the oldest. An
// entry is allocated on each accepted AR and retired on the RLAST beat of its
// response. Slave R channels are arbitrated round-robin onto the master R
// channel. A slave can be granted only when its RID is the oldest outstanding
// ID of its master. The grant is held until RLAST.
//
// Ports:
//   clk, rstn        clock; synchronous active-low reset
//   ar_valid, ar_id  AR issue from the master-side AR mux
//   ar_ready         ROB has space (!full, with no same-cycle bypass)
//   s_rvalid/s_rid/s_rlast  per-slave R channel; slave i RID is s_rid[i*IDW +: IDW]
//   s_rready         per-slave RREADY
//   m_rready         RREADY from the master side
//   r_grant          registered one-hot R mux select; zero when idle
//   count, full, empty  ROB fill level and status
//   orphan_err       sticky flag: an orphan response was drained
//
// Optional feature macro: ROB_ORPHAN_DRAIN_EN. When it is defined, a response
// whose RID matches no entry is drained and discarded. Without it, such a
// response is never accepted and orphan_err is tied low.
//
// state  | meaning
// IDLE   | no burst owns the R channel; evaluate eligibility each cycle
// BURST  | r_grant locked on one slave until its RLAST beat
// DRAIN  | (macro only) discard an orphan burst until RLAST, r_grant = 0

module rob_rd_sched #(
  parameter int DEPTH = 4,
  parameter int IDW   = 8,
  parameter int NS    = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ar_valid,
  input  logic [IDW-1:0]          ar_id,
  output logic                    ar_ready,
  input  logic [NS-1:0]           s_rvalid,
  input  logic [NS*IDW-1:0]       s_rid,
  input  logic [NS-1:0]           s_rlast,
  output logic [NS-1:0]           s_rready,
  input  logic                    m_rready,
  output logic [NS-1:0]           r_grant,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    orphan_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int PW = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW = IDW / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef ROB_ORPHAN_DRAIN_EN
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
`else
    ST_BURST = 2'd1
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ent_q [DEPTH];
  logic [IDW-1:0]  ent_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [NS-1:0]   grant_q, grant_d;
  logic [IW-1:0]   hit_q, hit_d;
  logic [PW-1:0]   rr_q, rr_d;

  logic            ar_fire;
  logic            retire;
  logic [CW-1:0]   alloc_idx;

  logic [NS-1:0]   elig;
  logic [NS-1:0]   seen_tag;
  logic [IW-1:0]   hit [NS];
  logic            win_found;
  logic [PW-1:0]   win_idx;
  int              rr_idx;

`ifdef ROB_ORPHAN_DRAIN_EN
  logic [NS-1:0]   orphan;
  logic [PW-1:0]   orph_idx;
  logic [PW-1:0]   drain_q, drain_d;
  logic            orphan_q, orphan_d;
`endif

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign ar_ready   = !full;
  assign ar_fire    = ar_valid && ar_ready;
  assign count      = count_q;
  assign r_grant    = grant_q;
`ifdef ROB_ORPHAN_DRAIN_EN
  assign orphan_err = orphan_q;
`else
  assign orphan_err = 1'b0;
`endif

  // The oldest entry carrying the RID's master tag must be the RID itself.
  // Any younger exact match is ignored because the older one blocks it.
  always_comb begin
    elig     = '0;
    seen_tag = '0;
`ifdef ROB_ORPHAN_DRAIN_EN
    orphan   = s_rvalid;
`endif
    for (int i = 0; i < NS; i++) begin
      hit[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j < int'(count_q)) begin
`ifdef ROB_ORPHAN_DRAIN_EN
          if (ent_q[j] == s_rid[i*IDW +: IDW]) orphan[i] = 1'b0;
`endif
          if (!seen_tag[i] && (ent_q[j][IDW-1:TW] == s_rid[i*IDW+TW +: IDW-TW])) begin
            seen_tag[i] = 1'b1;
            if (ent_q[j] == s_rid[i*IDW +: IDW]) begin
              elig[i] = s_rvalid[i];
              hit[i]  = IW'(j);
            end
          end
        end
      end
    end
  end

  // Round-robin pick, starting the search at rr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    for (int off = 0; off < NS; off++) begin
      rr_idx = int'(rr_q) + off;
      if (rr_idx >= NS) rr_idx = rr_idx - NS;
      if (!win_found && elig[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(rr_idx);
      end
    end
  end

`ifdef ROB_ORPHAN_DRAIN_EN
  always_comb begin
    orph_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (orphan[i]) orph_idx = PW'(i);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    hit_d    = hit_q;
    rr_d     = rr_q;
    retire   = 1'b0;
    s_rready = '0;
`ifdef ROB_ORPHAN_DRAIN_EN
    drain_d  = drain_q;
    orphan_d = orphan_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_BURST;
          grant_d = NS'(1) << win_idx;
          hit_d   = hit[win_idx];
          rr_d    = (win_idx == PW'(NS - 1)) ? '0 : win_idx + PW'(1);
        end
`ifdef ROB_ORPHAN_DRAIN_EN
        else if (|orphan) begin
          state_d  = ST_DRAIN;
          drain_d  = orph_idx;
          orphan_d = 1'b1;
        end
`endif
      end
      ST_BURST: begin
        s_rready = grant_q & {NS{m_rready}};
        if (m_rready && |(grant_q & s_rvalid & s_rlast)) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
`ifdef ROB_ORPHAN_DRAIN_EN
      ST_DRAIN: begin
        // Orphan beats are accepted regardless of the master side.
        s_rready = NS'(1) << drain_q;
        if (s_rvalid[drain_q] && s_rlast[drain_q]) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Retire compacts entries above hit_q down by one. A concurrent allocate
  // then lands at the new top, so it is still the youngest entry.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) ent_d[j] = ent_q[j];
    count_d   = count_q;
    alloc_idx = retire ? count_q - CW'(1) : count_q;
    if (retire) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        if (j >= int'(hit_q)) ent_d[j] = ent_q[j+1];
      end
    end
    if (ar_fire) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j == int'(alloc_idx)) ent_d[j] = ar_id;
      end
    end
    if (retire && !ar_fire)      count_d = count_q - CW'(1);
    else if (ar_fire && !retire) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      for (int j = 0; j < DEPTH; j++) ent_q[j] <= '0;
      count_q <= '0;
      grant_q <= '0;
      hit_q   <= '0;
      rr_q    <= '0;
`ifdef ROB_ORPHAN_DRAIN_EN
      drain_q  <= '0;
      orphan_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      for (int j = 0; j < DEPTH; j++) ent_q[j] <= ent_d[j];
      count_q <= count_d;
      grant_q <= grant_d;
      hit_q   <= hit_d;
      rr_q    <= rr_d;
`ifdef ROB_ORPHAN_DRAIN_EN
      drain_q  <= drain_d;
      orphan_q <= orphan_d;
`endif
    end
  end

endmodule

// File: tb/tb_rob_rd_sched.sv
// Testbench for rob_rd_sched. It uses a table of per-cycle vectors for a
// basic read. Hand-written sequences cover ordering, round-robin, full and
// concurrent operation, stall, reset and orphan responses.
// Inputs are driven 1 time unit after posedge and outputs are checked 2 time
// units after posedge.

module tb_rob_rd_sched;
  localparam int DEPTH = 4;
  localparam int IDW   = 8;
  localparam int NS    = 3;
  localparam int CW    = 3;
`ifdef ROB_ORPHAN_DRAIN_EN
  localparam bit DRAIN_EN = 1'b1;
`else
  localparam bit DRAIN_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              ar_valid = 1'b0;
  logic [IDW-1:0]    ar_id = '0;
  logic              ar_ready;
  logic [NS-1:0]     s_rvalid = '0;
  logic [NS*IDW-1:0] s_rid = '0;
  logic [NS-1:0]     s_rlast = '0;
  logic [NS-1:0]     s_rready;
  logic              m_rready = 1'b1;
  logic [NS-1:0]     r_grant;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              orphan_err;

  always #5 clk = ~clk;

  rob_rd_sched #(.DEPTH(DEPTH), .IDW(IDW), .NS(NS)) dut (
    .clk(clk), .rstn(rstn),
    .ar_valid(ar_valid), .ar_id(ar_id), .ar_ready(ar_ready),
    .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rlast(s_rlast), .s_rready(s_rready),
    .m_rready(m_rready), .r_grant(r_grant), .count(count),
    .full(full), .empty(empty), .orphan_err(orphan_err)
  );

  int checks = 0;
  int errors = 0;
  int beats  = 0;

  always @(posedge clk) begin
    if (rstn && m_rready && |(s_rvalid & s_rready)) beats++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic              av;
    logic [IDW-1:0]    aid;
    logic [NS-1:0]     rv;
    logic [NS*IDW-1:0] rid;
    logic [NS-1:0]     rl;
    logic              mr;
    logic [NS-1:0]     g;
    logic [NS-1:0]     rr;
    logic [CW-1:0]     cnt;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(logic av, logic [7:0] aid, logic [2:0] rv, logic [23:0] rid,
                              logic [2:0] rl, logic mr, logic [2:0] g, logic [2:0] rr,
                              logic [2:0] cnt);
    vec_t v;
    v.av = av; v.aid = aid; v.rv = rv; v.rid = rid; v.rl = rl; v.mr = mr;
    v.g = g; v.rr = rr; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ar_valid = 1'b0;
    ar_id    = '0;
    s_rvalid = '0;
    s_rid    = '0;
    s_rlast  = '0;
    m_rready = 1'b1;
  endtask

  task automatic do_reset();
    cyc();
    rstn = 1'b0;
    idle_in();
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  task automatic set_rid(input int s, input logic [IDW-1:0] id);
    s_rid[s*IDW +: IDW] = id;
  endtask

  task automatic alloc(input logic [IDW-1:0] id);
    ar_valid = 1'b1;
    ar_id    = id;
    cyc();
    ar_valid = 1'b0;
  endtask

  task automatic expect_st(input string tag, input logic [NS-1:0] g, input logic [NS-1:0] rr,
                           input logic [CW-1:0] cnt);
    #1;
    chk({tag, ".r_grant"},  32'(r_grant),  32'(g));
    chk({tag, ".s_rready"}, 32'(s_rready), 32'(rr));
    chk({tag, ".count"},    32'(count),    32'(cnt));
    chk({tag, ".full"},     32'(full),     32'(cnt == CW'(DEPTH)));
    chk({tag, ".empty"},    32'(empty),    32'(cnt == '0));
    chk({tag, ".ar_ready"}, 32'(ar_ready), 32'(cnt != CW'(DEPTH)));
  endtask

  task automatic wait_grant(output logic [NS-1:0] g, input int maxc);
    g = '0;
    for (int i = 0; i < maxc; i++) begin
      #1;
      if (r_grant != '0) begin
        g = r_grant;
        break;
      end
      cyc();
    end
  endtask

  // All three slaves present single-beat responses; the grant order is compared
  // with the expected slave sequence.
  task automatic rr_round(input string tag, input int e0, input int e1, input int e2);
    int order [3];
    logic [NS-1:0] pend;
    logic [NS-1:0] g;
    order[0] = e0; order[1] = e1; order[2] = e2;
    pend = 3'b111;
    s_rvalid = pend;
    s_rlast  = 3'b111;
    for (int n = 0; n < 3; n++) begin
      wait_grant(g, 6);
      chk($sformatf("%s.grant%0d", tag, n), 32'(g), 32'(3'b001 << order[n]));
      cyc();
      pend = pend & ~g;
      s_rvalid = pend;
    end
    s_rlast = '0;
  endtask

  initial begin
    logic [NS-1:0] g;

    // ---- basic single read, cycle table ----
    tbl[0] = mk(1'b1, 8'h12, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 3'b000, 3'd0);
    tbl[1] = mk(1'b0, 8'h00, 3'b010, 24'h001200, 3'b000, 1'b1, 3'b000, 3'b000, 3'd1);
    tbl[2] = mk(1'b0, 8'h00, 3'b010, 24'h001200, 3'b000, 1'b1, 3'b010, 3'b010, 3'd1);
    tbl[3] = mk(1'b0, 8'h00, 3'b010, 24'h001200, 3'b000, 1'b1, 3'b010, 3'b010, 3'd1);
    tbl[4] = mk(1'b0, 8'h00, 3'b010, 24'h001200, 3'b000, 1'b1, 3'b010, 3'b010, 3'd1);
    tbl[5] = mk(1'b0, 8'h00, 3'b010, 24'h001200, 3'b010, 1'b1, 3'b010, 3'b010, 3'd1);
    tbl[6] = mk(1'b0, 8'h00, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 3'b000, 3'd0);

    do_reset();
    beats = 0;
    #1;
    chk("reset.orphan_err", 32'(orphan_err), 32'd0);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cyc();
      ar_valid = tbl[k].av;
      ar_id    = tbl[k].aid;
      s_rvalid = tbl[k].rv;
      s_rid    = tbl[k].rid;
      s_rlast  = tbl[k].rl;
      m_rready = tbl[k].mr;
      expect_st($sformatf("vec%0d", k), tbl[k].g, tbl[k].rr, tbl[k].cnt);
    end
    chk("basic.beats", 32'(beats), 32'd4);

    // ---- per-master ordering ----
    do_reset();
    ar_valid = 1'b1; ar_id = 8'h10;
    expect_st("ord0", 3'b000, 3'b000, 3'd0);
    cyc();
    ar_id = 8'h11;
    expect_st("ord1", 3'b000, 3'b000, 3'd1);
    cyc();
    ar_valid = 1'b0;
    set_rid(0, 8'h11); set_rid(2, 8'h10);
    s_rvalid = 3'b101;
    expect_st("ord2", 3'b000, 3'b000, 3'd2);
    cyc();
    expect_st("ord3", 3'b100, 3'b100, 3'd2);
    cyc();
    s_rlast = 3'b100;
    expect_st("ord4", 3'b100, 3'b100, 3'd2);
    cyc();
    s_rvalid = 3'b001; s_rlast = 3'b000;
    expect_st("ord5", 3'b000, 3'b000, 3'd1);
    cyc();
    s_rlast = 3'b001;
    expect_st("ord6", 3'b001, 3'b001, 3'd1);
    cyc();
    s_rvalid = '0; s_rlast = '0;
    expect_st("ord7", 3'b000, 3'b000, 3'd0);

    // ---- round-robin ----
    do_reset();
    alloc(8'h10); alloc(8'h20); alloc(8'h30);
    set_rid(0, 8'h10); set_rid(1, 8'h20); set_rid(2, 8'h30);
    rr_round("rr1", 0, 1, 2);
    alloc(8'h40);
    set_rid(0, 8'h40);
    s_rvalid = 3'b001; s_rlast = 3'b001;
    wait_grant(g, 6);
    chk("rr.ptr_setup", 32'(g), 32'(3'b001));
    cyc();
    s_rvalid = '0; s_rlast = '0;
    alloc(8'h10); alloc(8'h20); alloc(8'h30);
    set_rid(0, 8'h10); set_rid(1, 8'h20); set_rid(2, 8'h30);
    rr_round("rr2", 1, 2, 0);
    #1;
    chk("rr.count", 32'(count), 32'd0);

    // ---- full, no bypass, concurrent allocate/retire ----
    do_reset();
    alloc(8'h10); alloc(8'h21); alloc(8'h32); alloc(8'h43);
    ar_valid = 1'b1; ar_id = 8'h54;
    set_rid(1, 8'h21); s_rvalid = 3'b010; s_rlast = 3'b010;
    expect_st("full0", 3'b000, 3'b000, 3'd4);
    cyc();
    expect_st("full1", 3'b010, 3'b010, 3'd4);
    cyc();
    s_rvalid = '0; s_rlast = '0;
    expect_st("full2", 3'b000, 3'b000, 3'd3);
    cyc();
    ar_valid = 1'b0;
    set_rid(0, 8'h10); s_rvalid = 3'b001; s_rlast = 3'b001;
    expect_st("full3", 3'b000, 3'b000, 3'd4);
    chk("full3.ent0", 32'(dut.ent_q[0]), 32'h10);
    chk("full3.ent1", 32'(dut.ent_q[1]), 32'h32);
    chk("full3.ent2", 32'(dut.ent_q[2]), 32'h43);
    chk("full3.ent3", 32'(dut.ent_q[3]), 32'h54);
    cyc();
    expect_st("full4", 3'b001, 3'b001, 3'd4);
    cyc();
    set_rid(2, 8'h32); s_rvalid = 3'b100; s_rlast = 3'b100;
    expect_st("conc0", 3'b000, 3'b000, 3'd3);
    cyc();
    ar_valid = 1'b1; ar_id = 8'h65;
    expect_st("conc1", 3'b100, 3'b100, 3'd3);
    cyc();
    ar_valid = 1'b0; s_rvalid = '0; s_rlast = '0;
    expect_st("conc2", 3'b000, 3'b000, 3'd3);
    chk("conc2.ent0", 32'(dut.ent_q[0]), 32'h43);
    chk("conc2.ent1", 32'(dut.ent_q[1]), 32'h54);
    chk("conc2.ent2", 32'(dut.ent_q[2]), 32'h65);

    // ---- stall with the last beat held, then reset mid-burst ----
    do_reset();
    beats = 0;
    alloc(8'h12);
    set_rid(1, 8'h12); s_rvalid = 3'b010;
    expect_st("stall0", 3'b000, 3'b000, 3'd1);
    cyc();
    expect_st("stall1", 3'b010, 3'b010, 3'd1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      m_rready = 1'b0; s_rlast = 3'b010;
      expect_st($sformatf("stall_hold%0d", k), 3'b010, 3'b000, 3'd1);
    end
    cyc();
    m_rready = 1'b1;
    expect_st("stall2", 3'b010, 3'b010, 3'd1);
    cyc();
    s_rvalid = '0; s_rlast = '0;
    expect_st("stall3", 3'b000, 3'b000, 3'd0);
    chk("stall.beats", 32'(beats), 32'd2);
    alloc(8'h12);
    s_rvalid = 3'b010;
    expect_st("rst0", 3'b000, 3'b000, 3'd1);
    cyc();
    expect_st("rst1", 3'b010, 3'b010, 3'd1);
    rstn = 1'b0;
    cyc();
    expect_st("rst2", 3'b000, 3'b000, 3'd0);
    rstn = 1'b1; s_rvalid = '0;

    // ---- orphan response ----
    do_reset();
    set_rid(2, 8'h77); s_rvalid = 3'b100; m_rready = 1'b0;
    expect_st("orph0", 3'b000, 3'b000, 3'd0);
    cyc();
    expect_st("orph1", 3'b000, DRAIN_EN ? 3'b100 : 3'b000, 3'd0);
    chk("orph1.orphan_err", 32'(orphan_err), 32'(DRAIN_EN));
    cyc();
    s_rlast = 3'b100;
    expect_st("orph2", 3'b000, DRAIN_EN ? 3'b100 : 3'b000, 3'd0);
    cyc();
    s_rvalid = '0; s_rlast = '0; m_rready = 1'b1;
    expect_st("orph3", 3'b000, 3'b000, 3'd0);
    chk("orph3.orphan_err", 32'(orphan_err), 32'(DRAIN_EN));
    do_reset();
    #1;
    chk("orph_rst.orphan_err", 32'(orphan_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
